// File: rtl/dmem_bus_bridge.sv
// Purpose: bridges the Memory-stage load/store request onto a valid/ready request bus with a separate response strobe.
// Latency: 3 cycles minimum from request to DONE (IDLE -> REQ -> WAIT -> DONE); a misaligned access reaches DONE after 1 cycle.
// Backpressure: holds the request while bus_ready is low, and stalls the pipeline until a response arrives or the timeout aborts the access.
//
// Ports:
//   clk, rst          - system clock; asynchronous active-low reset
//   MemReqM           - Memory-stage instruction is a load or store
//   MemWriteM         - 1 = store, 0 = load (qualified by MemReqM)
//   ALU_ResultM       - byte address; must be word aligned
//   WriteDataM        - store data
//   StallM            - freezes the pipeline up to and including Memory
//   ReadDataM/BusErrM - access result, presented in DONE and held until the next DONE
//   bus_valid/ready   - request handshake; bus_we/addr/wdata carry request attributes
//   bus_rvalid        - response strobe; bus_rdata/bus_err are qualified by it
module dmem_bus_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        BusErrM,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT);

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [4:0]  cnt_inc;
  logic        we_q, we_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic [31:0] rdata_q, rdata_nxt;
  logic        err_q, err_nxt;

  assign cnt_inc = cnt + 5'd1;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next-state and datapath update. The result registers only change on the
  // transition into DONE, so they hold their value across the following IDLE,
  // REQ and WAIT cycles of the next access.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_nxt    = we_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    rdata_nxt = rdata_q;
    err_nxt   = err_q;

    case (state)
      IDLE: begin
        if (MemReqM) begin
          if (ALU_ResultM[1:0] == 2'b00) begin
            we_nxt    = MemWriteM;
            addr_nxt  = ALU_ResultM;
            wdata_nxt = WriteDataM;
            state_nxt = REQ;
          end else begin
            // Misaligned: fail locally, never touch the bus.
            rdata_nxt = 32'd0;
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end
      end

      REQ: begin
        if (bus_ready) begin
          cnt_nxt   = 5'd0;
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        // A response on the final counted cycle still wins over the abort.
        if (bus_rvalid) begin
          rdata_nxt = we_q ? 32'd0 : bus_rdata;
          err_nxt   = bus_err;
          state_nxt = DONE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          cnt_nxt   = cnt_inc;
          rdata_nxt = 32'd0;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      DONE: begin
        // MemReqM here belongs to the next instruction; it is picked up in IDLE.
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The stall must rise in the same cycle the request appears, so it is
  // decoded combinationally from the IDLE request.
  assign StallM    = ((state == IDLE) && MemReqM) || (state == REQ) || (state == WAIT);
  assign bus_valid = (state == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign ReadDataM = rdata_q;
  assign BusErrM   = err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
module tb_dmem_bus_bridge;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALU_ResultM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        BusErrM;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd;
  logic        last_err;

  // One access: stimulus plus the expected observable outcome.
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          rdy;       // cycles bus_ready stays low while bus_valid is up
    int          rv;        // WAIT cycles before bus_rvalid (>= TIMEOUT: never)
    logic [31:0] rdata;
    logic        err;
    int          exp_stall; // cycles StallM is high
    int          exp_valid; // cycles bus_valid is high
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  dmem_bus_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .MemReqM     (MemReqM),
    .MemWriteM   (MemWriteM),
    .ALU_ResultM (ALU_ResultM),
    .WriteDataM  (WriteDataM),
    .StallM      (StallM),
    .ReadDataM   (ReadDataM),
    .BusErrM     (BusErrM),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome follows from alignment, how long the
  // slave delays ready/response, and the abort limit.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   wait_cycles;
    r = v;
    if (v.addr[1:0] != 2'b00) begin
      r.exp_stall = 1;
      r.exp_valid = 0;
      r.exp_rd    = 32'd0;
      r.exp_err   = 1'b1;
    end else begin
      r.exp_valid = v.rdy + 1;
      if (v.rv < TIMEOUT) begin
        wait_cycles = v.rv + 1;
        r.exp_rd    = v.we ? 32'd0 : v.rdata;
        r.exp_err   = v.err;
      end else begin
        wait_cycles = TIMEOUT;
        r.exp_rd    = 32'd0;
        r.exp_err   = 1'b1;
      end
      r.exp_stall = 1 + r.exp_valid + wait_cycles;
    end
    return r;
  endfunction

  // Called at a falling edge with the DUT in IDLE; returns one time unit after
  // the falling edge of the DONE cycle.
  task automatic run_txn(input vec_t v, input string name);
    bit in_wait;
    bit done;
    int stall_n;
    int valid_n;
    int wait_n;
    in_wait = 1'b0;
    done    = 1'b0;
    stall_n = 0;
    valid_n = 0;
    wait_n  = 0;
    MemReqM     = 1'b1;
    MemWriteM   = v.we;
    ALU_ResultM = v.addr;
    WriteDataM  = v.wdata;
    for (int c = 0; c < 200; c++) begin
      bus_ready  = 1'b0;
      bus_rvalid = 1'($urandom_range(0, 1));
      bus_rdata  = $urandom;
      bus_err    = 1'($urandom_range(0, 1));
      if (c == 1) begin
        // Pipeline inputs change after the request; the bridge must use its copy.
        ALU_ResultM = $urandom;
        WriteDataM  = $urandom;
        MemWriteM   = ~v.we;
      end
      #1;
      if (c == 0) begin
        chk({name, ".hold_rd"}, ReadDataM, last_rd);
        chk({name, ".hold_err"}, 32'(BusErrM), 32'(last_err));
      end
      if (!StallM) begin
        done = 1'b1;
        break;
      end
      stall_n++;
      if (bus_valid) begin
        chk({name, ".bus_addr"}, bus_addr, v.addr);
        chk({name, ".bus_wdata"}, bus_wdata, v.wdata);
        chk({name, ".bus_we"}, 32'(bus_we), 32'(v.we));
        bus_ready = (valid_n == v.rdy);
        if (valid_n == v.rdy) in_wait = 1'b1;
        valid_n++;
      end else if (in_wait) begin
        bus_rvalid = (wait_n == v.rv);
        if (wait_n == v.rv) begin
          bus_rdata = v.rdata;
          bus_err   = v.err;
        end
        wait_n++;
      end
      @(negedge clk);
    end
    if (!done) chk({name, ".reached_done"}, 32'd0, 32'd1);
    chk({name, ".stall_cycles"}, 32'(stall_n), 32'(v.exp_stall));
    chk({name, ".valid_cycles"}, 32'(valid_n), 32'(v.exp_valid));
    chk({name, ".rdata"}, ReadDataM, v.exp_rd);
    chk({name, ".buserr"}, 32'(BusErrM), 32'(v.exp_err));
    last_rd    = v.exp_rd;
    last_err   = v.exp_err;
    MemReqM    = 1'b0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  // Reset while an access is in flight (REQ or WAIT), then confirm silence.
  task automatic reset_mid(input bit to_wait, input string name);
    MemReqM     = 1'b1;
    MemWriteM   = 1'b0;
    ALU_ResultM = 32'h0000_0500;
    WriteDataM  = 32'hA5A5_A5A5;
    bus_ready   = to_wait;
    bus_rvalid  = 1'b0;
    @(negedge clk);
    #1 chk({name, ".valid_before"}, 32'(bus_valid), 32'd1);
    @(negedge clk);
    MemReqM   = 1'b0;
    bus_ready = 1'b0;
    #1 chk({name, ".stall_before"}, 32'(StallM), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk({name, ".valid"}, 32'(bus_valid), 32'd0);
    chk({name, ".stall"}, 32'(StallM), 32'd0);
    chk({name, ".rdata"}, ReadDataM, 32'd0);
    chk({name, ".buserr"}, 32'(BusErrM), 32'd0);
    chk({name, ".addr"}, bus_addr, 32'd0);
    chk({name, ".wdata"}, bus_wdata, 32'd0);
    chk({name, ".we"}, 32'(bus_we), 32'd0);
    // In IDLE the stall must follow the request combinationally.
    MemReqM = 1'b1;
    #1 chk({name, ".idle_stall"}, 32'(StallM), 32'd1);
    MemReqM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk({name, ".quiet_valid"}, 32'(bus_valid), 32'd0);
      chk({name, ".quiet_stall"}, 32'(StallM), 32'd0);
      @(negedge clk);
    end
    last_rd  = 32'd0;
    last_err = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   gap;

    tbl[0] = '{32'h0000_0100, 1'b0, 32'h0000_0000, 0, 0,   32'hCAFE_F00D, 1'b0, 3,  1, 32'hCAFE_F00D, 1'b0};
    tbl[1] = '{32'h0000_0204, 1'b1, 32'h1234_5678, 4, 0,   32'hDEAD_BEEF, 1'b0, 7,  5, 32'h0000_0000, 1'b0};
    tbl[2] = '{32'h0000_0103, 1'b0, 32'h0000_0000, 0, 0,   32'h1111_1111, 1'b0, 1,  0, 32'h0000_0000, 1'b1};
    tbl[3] = '{32'h0000_0300, 1'b0, 32'h0000_0000, 0, 100, 32'h2222_2222, 1'b0, 18, 1, 32'h0000_0000, 1'b1};
    tbl[4] = '{32'h0000_040C, 1'b0, 32'h0000_0000, 1, 2,   32'h0000_55AA, 1'b1, 6,  2, 32'h0000_55AA, 1'b1};
    tbl[5] = '{32'h0000_0410, 1'b0, 32'h0000_0000, 0, 0,   32'h0BAD_CAFE, 1'b0, 3,  1, 32'h0BAD_CAFE, 1'b0};
    tbl[6] = '{32'h0000_0500, 1'b0, 32'h0000_0000, 0, 15,  32'h1357_9BDF, 1'b0, 18, 1, 32'h1357_9BDF, 1'b0};
    tbl[7] = '{32'h0000_0202, 1'b1, 32'hFFFF_0000, 0, 0,   32'h3333_3333, 1'b0, 1,  0, 32'h0000_0000, 1'b1};

    rst         = 1'b0;
    MemReqM     = 1'b0;
    MemWriteM   = 1'b0;
    ALU_ResultM = 32'd0;
    WriteDataM  = 32'd0;
    bus_ready   = 1'b0;
    bus_rvalid  = 1'b0;
    bus_rdata   = 32'd0;
    bus_err     = 1'b0;
    last_rd     = 32'd0;
    last_err    = 1'b0;

    #1;
    chk("reset.stall", 32'(StallM), 32'd0);
    chk("reset.valid", 32'(bus_valid), 32'd0);
    chk("reset.rdata", ReadDataM, 32'd0);
    chk("reset.buserr", 32'(BusErrM), 32'd0);
    chk("reset.addr", bus_addr, 32'd0);
    chk("reset.wdata", bus_wdata, 32'd0);
    chk("reset.we", 32'(bus_we), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed table, issued back to back; DONE must ignore a waiting request.
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
      if (i < 7) begin
        MemReqM     = 1'b1;
        ALU_ResultM = tbl[i + 1].addr;
        #1 chk($sformatf("vec%0d.done_stall", i), 32'(StallM), 32'd0);
      end
      @(negedge clk);
    end

    reset_mid(1'b1, "rst_wait");
    reset_mid(1'b0, "rst_req");

    v = '{32'h0000_0600, 1'b0, 32'h0, 0, 0, 32'h600D_600D, 1'b0, 0, 0, 32'h0, 1'b0};
    run_txn(model(v), "after_rst");
    @(negedge clk);

    // Randomized accesses against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      v.addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) v.addr[1:0] = 2'($urandom_range(1, 3));
      v.we    = 1'($urandom_range(0, 1));
      v.wdata = $urandom;
      v.rdy   = $urandom_range(0, 5);
      v.rv    = $urandom_range(0, 20);
      v.rdata = $urandom;
      v.err   = ($urandom_range(0, 3) == 0);
      run_txn(model(v), $sformatf("rand%0d", n));
      @(negedge clk);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        #1;
        chk($sformatf("rand%0d.idle_stall", n), 32'(StallM), 32'd0);
        chk($sformatf("rand%0d.idle_valid", n), 32'(bus_valid), 32'd0);
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
